// File: rtl/cpu_clk_pkg.sv
// Shared mode encodings, FSM state type and decode helper for the CPU clock controller.
// Optional cycle counter enabled by defining CPU_CLK_CNT_EN.
package cpu_clk_pkg;

   localparam logic [1:0] MODE_HALT     = 2'b00;
   localparam logic [1:0] MODE_RUN      = 2'b01;
   localparam logic [1:0] MODE_STEP     = 2'b10;
   localparam logic [1:0] MODE_HALT_ALT = 2'b11;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned CYC_CNT_W   = 32;

   typedef enum logic [1:0] {
      HALT = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   // Both halt encodings collapse to HALT.
   function automatic state_t mode_decode(input logic [1:0] mode);
      state_t st;
      case (mode)
         MODE_RUN:  st = RUN;
         MODE_STEP: st = STEP;
         default:   st = HALT;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter: btn_db toggles once the
// synchronised button has disagreed with it for DB_CYCLES consecutive cycles.
module btn_debounce
   import cpu_clk_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 1000
) (
   input  logic clk_in,
   input  logic rst,
   input  logic btn,
   output logic btn_db
);

   localparam int unsigned     CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   btn_s;

   assign btn_s = sync_q[SYNC_STAGES-1];

   // Any cycle of agreement restarts the stability window.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         btn_db <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
         if (btn_s == btn_db) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            btn_db <= ~btn_db;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: halt, free-running divided clock, or single step
// from a debounced button. Define CPU_CLK_CNT_EN to add the cyc_cnt pulse counter.
module cpu_clk_ctrl
   import cpu_clk_pkg::*;
#(
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned DB_CYCLES = 1000
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   input  logic             btn,
   output logic             btn_db,
   output logic             cpu_en
`ifdef CPU_CLK_CNT_EN
   ,
   output logic [CYC_CNT_W-1:0] cyc_cnt
`endif
);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             btn_db_q;
   logic             cpu_en_d;
   logic             div_term;
   logic             step_rise;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_btn_debounce (
      .clk_in (clk_in),
      .rst    (rst),
      .btn    (btn),
      .btn_db (btn_db)
   );

   // >= so a divisor lowered below the running count still terminates at once.
   assign div_term  = (div_cnt_q >= div);
   assign step_rise = btn_db & ~btn_db_q;

   // Pulses are only issued when the state is unchanged across the edge.
   always_comb begin
      state_d   = mode_decode(mode);
      div_cnt_d = '0;
      cpu_en_d  = 1'b0;
      case (state_q)
         RUN: begin
            div_cnt_d = div_term ? '0 : div_cnt_q + DIV_W'(1);
            cpu_en_d  = div_term && (state_d == RUN);
         end
         STEP: begin
            cpu_en_d = step_rise && (state_d == STEP);
         end
         default: ;
      endcase
   end

   // btn_db_q tracks in every state so edges seen outside STEP are consumed.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q   <= HALT;
         div_cnt_q <= '0;
         btn_db_q  <= 1'b0;
         cpu_en    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         btn_db_q  <= btn_db;
         cpu_en    <= cpu_en_d;
      end
   end

`ifdef CPU_CLK_CNT_EN
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cyc_cnt <= '0;
      end else if (cpu_en_d) begin
         cyc_cnt <= cyc_cnt + CYC_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: a per-cycle vector table for reset/run/halt
// behaviour plus hand sequences for debounce, step gating, reset and divisor change.
module tb_cpu_clk_ctrl;

   localparam int unsigned DIV_W = 16;
   localparam int unsigned DB    = 8;
   localparam int          NVEC  = 23;

   logic             clk_in;
   logic             rst;
   logic [1:0]       mode;
   logic [DIV_W-1:0] div;
   logic             btn;
   logic             btn_db;
   logic             cpu_en;
`ifdef CPU_CLK_CNT_EN
   logic [31:0]      cyc_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   cpu_clk_ctrl #(
      .DIV_W     (DIV_W),
      .DB_CYCLES (DB)
   ) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .mode   (mode),
      .div    (div),
      .btn    (btn),
      .btn_db (btn_db),
      .cpu_en (cpu_en)
`ifdef CPU_CLK_CNT_EN
      ,
      .cyc_cnt (cyc_cnt)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic             rst;
      logic [1:0]       mode;
      logic [DIV_W-1:0] div;
      logic             exp_en;
   } vec_t;

   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic r, input logic [1:0] m, input int d, input logic e);
      vec_t v;
      v.rst    = r;
      v.mode   = m;
      v.div    = DIV_W'(d);
      v.exp_en = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic run(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         tick();
         if (cpu_en === 1'b1) pulses++;
      end
   endtask

   int p;

   initial begin
      rst  = 1'b1;
      mode = 2'b00;
      div  = '0;
      btn  = 1'b0;

      // Row 1 is the entry edge into RUN; div=3 pulses on entry cycles 4, 8, 12.
      vecs[0] = mk(1'b1, 2'b01, 3, 1'b0);
      for (int i = 1; i <= 13; i++)
         vecs[i] = mk(1'b0, 2'b01, 3, (i == 5) || (i == 9) || (i == 13));
      vecs[14] = mk(1'b0, 2'b00, 3, 1'b0);
      vecs[15] = mk(1'b0, 2'b00, 3, 1'b0);
      vecs[16] = mk(1'b0, 2'b01, 0, 1'b0);
      vecs[17] = mk(1'b0, 2'b01, 0, 1'b1);
      vecs[18] = mk(1'b0, 2'b01, 0, 1'b1);
      vecs[19] = mk(1'b0, 2'b01, 0, 1'b1);
      vecs[20] = mk(1'b0, 2'b11, 0, 1'b0);  // terminal count on mode change: no pulse
      vecs[21] = mk(1'b0, 2'b11, 0, 1'b0);
      vecs[22] = mk(1'b0, 2'b10, 0, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         rst  = vecs[i].rst;
         mode = vecs[i].mode;
         div  = vecs[i].div;
         tick();
         chk($sformatf("vec%0d_cpu_en", i), 32'(cpu_en), 32'(vecs[i].exp_en));
         chk($sformatf("vec%0d_btn_db", i), 32'(btn_db), 32'h0);
      end

      // Debounce in STEP: a 5-cycle glitch is rejected, a stable press gives one pulse.
      btn = 1'b1;
      run(5, p);
      btn = 1'b0;
      run(12, p);
      chk("glitch_pulses", 32'(p), 32'd0);
      chk("glitch_btn_db", 32'(btn_db), 32'h0);
      btn = 1'b1;
      run(DB + 1, p);
      chk("db_not_yet", 32'(btn_db), 32'h0);
      tick();
      chk("db_rise", 32'(btn_db), 32'h1);
      tick();
      chk("step_pulse", 32'(cpu_en), 32'h1);
      run(9, p);
      chk("step_single", 32'(p), 32'd0);
      btn = 1'b0;
      run(15, p);
      chk("release_pulses", 32'(p), 32'd0);
      chk("release_btn_db", 32'(btn_db), 32'h0);

      // Press in HALT is discarded after switching to STEP; next press pulses once.
      mode = 2'b00;
      btn  = 1'b1;
      run(15, p);
      chk("halt_press_pulses", 32'(p), 32'd0);
      chk("halt_press_btn_db", 32'(btn_db), 32'h1);
      mode = 2'b10;
      run(10, p);
      chk("stale_edge_pulses", 32'(p), 32'd0);
      btn = 1'b0;
      run(15, p);
      chk("gating_release", 32'(p), 32'd0);
      btn = 1'b1;
      run(15, p);
      chk("gating_press", 32'(p), 32'd1);
      btn = 1'b0;
      run(15, p);

      // Step edge coinciding with a mode change produces nothing.
      btn = 1'b1;
      run(DB + 2, p);
      chk("edge_pre_pulses", 32'(p), 32'd0);
      chk("edge_btn_db", 32'(btn_db), 32'h1);
      mode = 2'b00;
      tick();
      chk("edge_modechg", 32'(cpu_en), 32'h0);
      run(5, p);
      chk("edge_after", 32'(p), 32'd0);
      btn = 1'b0;
      run(15, p);

      // Reset while the divider is at 4 of 5; first pulse 6 cycles after re-entry.
      mode = 2'b01;
      div  = DIV_W'(5);
      tick();
      run(4, p);
      chk("prereset_pulses", 32'(p), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("reset_cpu_en%0d", i), 32'(cpu_en), 32'h0);
`ifdef CPU_CLK_CNT_EN
         chk($sformatf("reset_cyc_cnt%0d", i), cyc_cnt, 32'h0);
`endif
      end
      rst = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("postreset_low%0d", i), 32'(cpu_en), 32'h0);
      end
      tick();
      chk("postreset_first", 32'(cpu_en), 32'h1);

      // Divisor lowered from 20 to 4 with the counter at 10.
      mode = 2'b00;
      tick();
      mode = 2'b01;
      div  = DIV_W'(20);
      tick();
      run(10, p);
      chk("shrink_pre", 32'(p), 32'd0);
      div = DIV_W'(4);
      tick();
      chk("shrink_immediate", 32'(cpu_en), 32'h1);
      for (int k = 0; k < 2; k++) begin
         run(4, p);
         chk($sformatf("shrink_gap%0d", k), 32'(p), 32'd0);
         tick();
         chk($sformatf("shrink_pulse%0d", k), 32'(cpu_en), 32'h1);
      end

`ifdef CPU_CLK_CNT_EN
      // Pulse counter wraps from all-ones to zero.
      mode = 2'b00;
      tick();
      force dut.cyc_cnt = 32'hFFFF_FFFF;
      tick();
      release dut.cyc_cnt;
      chk("cnt_preload", cyc_cnt, 32'hFFFF_FFFF);
      mode = 2'b10;
      btn  = 1'b1;
      run(15, p);
      chk("cnt_wrap_pulses", 32'(p), 32'd1);
      chk("cnt_wrap", cyc_cnt, 32'h0);
      btn = 1'b0;
      run(15, p);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning width of the run-mode divisor.
REQ-002 SHALL have parameter DB_CYCLES, default 1000, meaning the number of stable cycles required to accept a button change.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port mode, input, 2 bits: 00 halt, 01 run, 10 step, 11 halt.
REQ-006 SHALL have port div, input, DIV_W bits: run-mode period minus one.
REQ-007 SHALL have port btn, input, 1 bit: raw, asynchronous, bouncing step button.
REQ-008 SHALL have port btn_db, output, 1 bit: debounced button level.
REQ-009 SHALL have port cpu_en, output, 1 bit: one-cycle clock-enable pulse to the CPU.
REQ-010 SHALL have port cyc_cnt, output, 32 bits: count of issued cpu_en pulses; present only with CPU_CLK_CNT_EN.

Function
REQ-011 SHALL synchronise btn through two flip-flops before any other use.
REQ-012 SHALL count cycles while the synchronised btn differs from btn_db, and SHALL clear the count on any cycle where they are equal.
REQ-013 SHALL toggle btn_db and clear the count when the count reaches DB_CYCLES-1.
REQ-014 SHALL implement an FSM with states HALT, RUN and STEP, selected from mode every cycle; the state is the registered decode of mode.
REQ-015 SHALL keep cpu_en at 0 in HALT.
REQ-016 SHALL, in RUN, use a divider counter that runs from 0 to div; cpu_en SHALL be 1 for exactly one cycle when the counter equals div, and the counter SHALL then return to 0.
REQ-017 SHALL, with div=0, assert cpu_en on every cycle in RUN.
REQ-018 SHALL, if div is lowered below the current counter value, treat counter>=div as terminal: pulse cpu_en and wrap to 0.
REQ-019 SHALL clear the divider counter on entry to RUN, so the first pulse occurs div+1 cycles after entry.
REQ-020 SHALL, in STEP, produce exactly one cpu_en pulse the cycle after each rising edge of btn_db.
REQ-021 SHALL discard btn_db edges that occur outside STEP; they SHALL NOT produce a pulse after a later switch into STEP.
REQ-022 SHALL produce no pulse on the entry cycle when mode changes in the same cycle as a terminal count or a step edge; the new state governs.
REQ-023 SHALL drive cpu_en from a register.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set the state to HALT, cpu_en=0, btn_db=0, the debounce count, divider counter and synchroniser to 0, and cyc_cnt=0.
REQ-025 SHALL give rst priority over all other inputs; a pulse in flight during reset SHALL be suppressed.
REQ-026 SHALL, after rst deasserts, take the state from mode on the next edge.

Configuration
REQ-027 SHALL, with macro CPU_CLK_CNT_EN defined, include cyc_cnt, incrementing on each cpu_en and wrapping from 0xFFFFFFFF to 0.
REQ-028 SHALL, without CPU_CLK_CNT_EN, omit the cyc_cnt port and its counter; all other behaviour is identical.

Structure
REQ-029 SHALL place the mode encodings (localparams) and the FSM state enum in a shared package cpu_clk_pkg.
REQ-030 SHALL place the synchroniser and debounce logic in sub-module btn_debounce, with ports clk_in, rst, btn, btn_db and parameter DB_CYCLES.

Verification
REQ-031 Run cadence: mode=01, div=3 -> cpu_en high on cycles 4, 8 and 12 after entry, low on all other cycles.
REQ-032 Debounce: DB_CYCLES=8; btn glitches high for 5 cycles, then holds high for 20 cycles -> btn_db rises once, 8 cycles plus 2 sync cycles after the stable rise; exactly one cpu_en pulse in STEP.
REQ-033 Mode gating: btn pressed in HALT, then mode set to 10 -> no cpu_en; a subsequent press -> one pulse.
REQ-034 Reset mid-run: div=5, rst asserted on counter value 4 -> cpu_en stays 0 and cyc_cnt=0; after release with mode=01, the first pulse arrives 6 cycles later.
REQ-035 Divisor shrink: counter at 10 with div=20, div changed to 4 -> pulse next cycle, then a period of 5.
REQ-036 Counter wrap (CPU_CLK_CNT_EN): cyc_cnt preloaded to 0xFFFFFFFF via force, one pulse -> cyc_cnt=0.
